// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command parser: FSM states,
// error codes and the ASCII characters the parser recognises.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    DATA_HI,
    DATA_LO,
    WAIT_EOL,
    ISSUE,
    DISCARD
  } state_t;

  localparam logic [1:0] ERR_SYNTAX  = 2'd1;
  localparam logic [1:0] ERR_FRAME   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_W_UP = 8'h57;
  localparam logic [7:0] ASCII_W_LO = 8'h77;
  localparam logic [7:0] ASCII_R_UP = 8'h52;
  localparam logic [7:0] ASCII_R_LO = 8'h72;

  function automatic logic is_eol_char(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_hex_decode.sv
// Combinational ASCII hex digit decoder: accepts 0-9, A-F and a-f and
// returns the nibble value together with a validity flag.
module hex_ascii_decode (
  input  logic [7:0] ascii,
  output logic [3:0] nibble,
  output logic       is_hex
);

  // Letters A-F/a-f carry their value minus 9 in the low nibble.
  always_comb begin
    nibble = 4'd0;
    is_hex = 1'b0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      nibble = ascii[3:0];
      is_hex = 1'b1;
    end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                 (ascii >= 8'h61 && ascii <= 8'h66)) begin
      nibble = ascii[3:0] + 4'd9;
      is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses ASCII "W AA DD <eol>" / "R AA <eol>" commands from a UART byte
// stream and issues one register-bus request per well-formed command.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int TIMEOUT_MS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       framing_error,
  output logic       req_valid,
  input  logic       req_ready,
  output logic       req_write,
  output logic [7:0] req_addr,
  output logic [7:0] req_wdata,
  output logic       cmd_error,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int TIMEOUT_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic          overrun;
  logic [3:0]    nibble;
  logic          is_hex;
  logic          is_eol;
  logic          is_write_cmd;
  logic          is_read_cmd;
  logic          counting;
  logic          tick_out;

  hex_ascii_decode u_hex (
    .ascii  (rx_byte),
    .nibble (nibble),
    .is_hex (is_hex)
  );

  assign is_eol       = is_eol_char(rx_byte);
  assign is_write_cmd = (rx_byte == ASCII_W_UP) || (rx_byte == ASCII_W_LO);
  assign is_read_cmd  = (rx_byte == ASCII_R_UP) || (rx_byte == ASCII_R_LO);
  assign counting     = (state != IDLE) && (state != ISSUE);
  // A byte or framing strobe on the terminal-count cycle beats the timeout.
  assign tick_out     = (timer == TC_LAST) && !rx_valid && !framing_error;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_valid <= 1'b0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      cmd_error <= 1'b0;
      err_code  <= '0;
      timer     <= '0;
      overrun   <= 1'b0;
    end else begin
      cmd_error <= 1'b0;

      if (rx_valid || framing_error || !counting) timer <= '0;
      else                                        timer <= timer + 1'b1;

      case (state)
        IDLE: begin
          if (framing_error) begin
            cmd_error <= 1'b1;
            err_code  <= ERR_FRAME;
            state     <= DISCARD;
          end else if (rx_valid) begin
            if (is_write_cmd || is_read_cmd) begin
              req_write <= is_write_cmd;
              req_addr  <= '0;
              req_wdata <= '0;
              state     <= ADDR_HI;
            end else if (!is_eol) begin
              cmd_error <= 1'b1;
              err_code  <= ERR_SYNTAX;
              state     <= DISCARD;
            end
          end
        end

        ADDR_HI, ADDR_LO, DATA_HI, DATA_LO: begin
          if (framing_error) begin
            cmd_error <= 1'b1;
            err_code  <= ERR_FRAME;
            state     <= DISCARD;
          end else if (rx_valid && !is_hex) begin
            cmd_error <= 1'b1;
            err_code  <= ERR_SYNTAX;
            state     <= DISCARD;
          end else if (rx_valid) begin
            case (state)
              ADDR_HI: begin
                req_addr <= {req_addr[3:0], nibble};
                state    <= ADDR_LO;
              end
              ADDR_LO: begin
                req_addr <= {req_addr[3:0], nibble};
                state    <= req_write ? DATA_HI : WAIT_EOL;
              end
              DATA_HI: begin
                req_wdata <= {req_wdata[3:0], nibble};
                state     <= DATA_LO;
              end
              default: begin
                req_wdata <= {req_wdata[3:0], nibble};
                state     <= WAIT_EOL;
              end
            endcase
          end else if (tick_out) begin
            cmd_error <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= IDLE;
          end
        end

        WAIT_EOL: begin
          if (framing_error) begin
            cmd_error <= 1'b1;
            err_code  <= ERR_FRAME;
            state     <= DISCARD;
          end else if (rx_valid) begin
            if (is_eol) begin
              req_valid <= 1'b1;
              state     <= ISSUE;
            end else begin
              cmd_error <= 1'b1;
              err_code  <= ERR_SYNTAX;
              state     <= DISCARD;
            end
          end else if (tick_out) begin
            cmd_error <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= IDLE;
          end
        end

        // Bytes arriving while the request is pending are lost; the rest of
        // that line must be thrown away once the request completes.
        ISSUE: begin
          if (rx_valid || framing_error) begin
            cmd_error <= 1'b1;
            err_code  <= ERR_FRAME;
          end
          if (req_ready) begin
            req_valid <= 1'b0;
            overrun   <= 1'b0;
            state     <= (overrun || rx_valid || framing_error) ? DISCARD : IDLE;
          end else if (rx_valid || framing_error) begin
            overrun <= 1'b1;
          end
        end

        DISCARD: begin
          if (rx_valid && !framing_error && is_eol) state <= IDLE;
          else if (tick_out)                        state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of uart_rx and consumes its rx_valid/rx_byte/framing_error stream.
- Parses ASCII hex commands, "W" AA DD terminator for a write and "R" AA terminator for a read, where AA/DD are two hex digits and the terminator is CR or LF.
- Issues one register-bus request per valid command over a valid/ready handshake.
- Flags syntax, framing, overrun and inter-byte timeout errors.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- TIMEOUT_MS, 10, maximum idle gap between bytes inside a command. TIMEOUT_CYCLES = CLK_FREQ/1000*TIMEOUT_MS.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe from uart_rx; rx_byte is valid on this cycle.
- rx_byte  in  8  received byte.
- framing_error  in  1  one-cycle strobe from uart_rx for a bad stop bit.
- req_valid  out  1  bus request pending.
- req_ready  in  1  bus accepts the request when high together with req_valid.
- req_write  out  1  1 = write, 0 = read.
- req_addr  out  8  register address.
- req_wdata  out  8  write data; 0 for reads.
- cmd_error  out  1  one-cycle error strobe.
- err_code  out  2  reason for the last error, held until the next error: 1 = syntax, 2 = framing/overrun, 3 = timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state = IDLE; req_valid, req_write, cmd_error, busy = 0; req_addr, req_wdata, err_code = 0; timeout counter and overrun flag cleared. Reset asserted mid-command or during ISSUE drops the command with no error strobe.
- States and transitions:
  - IDLE: 'W'/'w' -> ADDR_HI with write=1; 'R'/'r' -> ADDR_HI with write=0; CR/LF ignored (blank lines); any other byte -> syntax error, DISCARD.
  - ADDR_HI, ADDR_LO: hex digit (0-9, A-F, a-f) shifts a nibble into addr, high nibble first. ADDR_LO goes to DATA_HI if write, else to WAIT_EOL.
  - DATA_HI, DATA_LO: same rule, filling wdata. DATA_LO -> WAIT_EOL.
  - WAIT_EOL: CR or LF -> ISSUE; anything else -> syntax error, DISCARD.
  - ISSUE: req_valid = 1 with req_write/addr/wdata stable; hold until req_ready. On handshake: overrun flag set -> DISCARD, else -> IDLE. req_valid drops the cycle after the handshake.
  - DISCARD: drop bytes until CR/LF, then -> IDLE. No further error strobes in this state.
- Any non-hex byte in a hex state: syntax error -> DISCARD.
- Latency: terminator accepted on cycle N -> req_valid = 1 on cycle N+1. With req_ready tied high, the request lasts exactly one cycle.
- Error strobe: cmd_error pulses for exactly one cycle on the cycle after the offending event; err_code updates on the same cycle.
- framing_error in IDLE, the hex states or WAIT_EOL: error code 2 -> DISCARD. The byte delivered with it, if any, is ignored.
- rx_valid or framing_error during ISSUE: byte dropped, error code 2 pulsed, overrun flag set. The pending request still completes unchanged.
- Timeout:
  - Counter clears on every rx_valid and counts while in ADDR_HI..WAIT_EOL or DISCARD.
  - Reaching TIMEOUT_CYCLES-1 -> error code 3 pulse and return to IDLE. DISCARD times out silently to IDLE, with no strobe.
  - If rx_valid lands on the terminal-count cycle, the byte wins and the counter clears.
  - Counter does not run in IDLE or ISSUE.
- Simultaneous rx_valid and framing_error: framing takes priority.
- Command letters are case-insensitive; letters appearing in hex positions are syntax errors, except A-F/a-f.

Decomposition:
- Package uart_cmd_pkg:
  - state enum: IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, WAIT_EOL, ISSUE, DISCARD.
  - error-code constants: ERR_SYNTAX = 1, ERR_FRAME = 2, ERR_TIMEOUT = 3.
  - ASCII constants: CR 8'h0D, LF 8'h0A, 'W', 'w', 'R', 'r'.
- One sub-module, hex_ascii_decode: combinational, byte in -> 4-bit nibble plus is_hex flag.
- Timeout counter is inlined; width $clog2(TIMEOUT_CYCLES).

Test Plan:
- Send "W3A5C\r" through uart_rx at 115200 with req_ready = 1 -> one req_valid cycle with req_write = 1, req_addr = 8'h3A, req_wdata = 8'h5C; no cmd_error.
- Send "r7f\n" with req_ready held low for 20 cycles -> req_valid held 20+ cycles with addr = 8'h7F, write = 0, wdata = 0; drops the cycle after req_ready rises.
- Send "W3G12\r" -> cmd_error pulse with err_code = 1 after 'G'; no request; a following "R01\r" issues addr = 8'h01.
- Send "W1", then no bytes for TIMEOUT_CYCLES (TIMEOUT_MS = 1 in bench) -> cmd_error with err_code = 3, busy = 0; a later "R22\r" is accepted.
- Send "R10\r", hold req_ready low, inject byte 'X' -> err_code = 2 pulse; request addr = 8'h10 completes; block discards until the next CR, then "W0102\r" issues normally.
- Assert rst during DATA_LO of "W1234" -> all outputs at reset values the next cycle; no request and no error strobe.
